// File: rtl/reg_file_scoreboard.sv
// Register file with PC aliasing, link write, PC-write redirect and a per-register busy scoreboard.
// Optional macro RF_WRITE_BYPASS_EN forwards same-cycle writes and link writes to the read ports.
module reg_file_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int PC_IDX    = 15,
  parameter int LR_IDX    = 14,
  parameter int PC_OFFSET = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_val,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] rd_addr_c,
  input  logic              rd_use_a,
  input  logic              rd_use_b,
  input  logic              rd_use_c,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_c,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic              issue_en,
  input  logic              issue_dest_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              stall,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] LR_ADDR = ADDR_W'(LR_IDX);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                redirect_q, redirect_d;
  logic [DATA_W-1:0]   target_q, target_d;

  logic [DATA_W-1:0] pcRead;
  logic [DATA_W-1:0] linkValue;
  logic              wrArray;
  logic              wrPc;
  logic              linkWrite;
  logic              issueAccept;

  logic [ADDR_W-1:0] rdAddr [3];
  logic [DATA_W-1:0] rdData [3];
  logic [2:0]        rdBusy;
  logic [2:0]        rdUse;

  assign pcRead    = pc_val + DATA_W'(PC_OFFSET);
  assign linkValue = pc_val + DATA_W'(4);
  assign wrArray   = wr_en && (wr_addr != PC_ADDR);
  assign wrPc      = wr_en && (wr_addr == PC_ADDR);
  // The data write port owns LR when both it and the link write target it.
  assign linkWrite = link_en && !(wr_en && (wr_addr == LR_ADDR));

  assign rdAddr[0] = rd_addr_a;
  assign rdAddr[1] = rd_addr_b;
  assign rdAddr[2] = rd_addr_c;
  assign rdUse     = {rd_use_c, rd_use_b, rd_use_a};

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdData[p] = regs_q[rdAddr[p]];
      rdBusy[p] = busy_q[rdAddr[p]];
`ifdef RF_WRITE_BYPASS_EN
      if (wrArray && (wr_addr == rdAddr[p])) begin
        rdData[p] = wr_data;
        rdBusy[p] = 1'b0;
      end else if (linkWrite && (rdAddr[p] == LR_ADDR)) begin
        rdData[p] = linkValue;
        rdBusy[p] = 1'b0;
      end
`endif
      // The PC alias is never stored, so it overrides any array or bypass value.
      if (rdAddr[p] == PC_ADDR) begin
        rdData[p] = pcRead;
        rdBusy[p] = 1'b0;
      end
    end
  end

  assign rd_data_a = rdData[0];
  assign rd_data_b = rdData[1];
  assign rd_data_c = rdData[2];
  assign busy_a    = rdBusy[0];
  assign busy_b    = rdBusy[1];
  assign busy_c    = rdBusy[2];

  assign stall = issue_en &&
                 ((|(rdUse & rdBusy)) || (issue_dest_en && busy_q[issue_addr]));
  assign issueAccept = issue_en && issue_dest_en && !stall && (issue_addr != PC_ADDR);

  always_comb begin
    regs_d = regs_q;
    if (linkWrite && (LR_ADDR != PC_ADDR)) begin
      regs_d[LR_ADDR] = linkValue;
    end
    if (wrArray) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Clears are applied before the set so a new producer keeps its register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (link_en) begin
      busy_d[LR_ADDR] = 1'b0;
    end
    if (issueAccept) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[PC_ADDR] = 1'b0;
  end

  always_comb begin
    redirect_d = wrPc;
    target_d   = wrPc ? (wr_data & ~DATA_W'(3)) : target_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
    end
  end

  assign pc_redirect = redirect_q;
  assign pc_target   = target_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard: a driver pushes expectations from an array-based model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file_scoreboard;

  typedef struct packed {
    logic        reset;
    logic [31:0] pc;
    logic [3:0]  ra, rb, rc;
    logic        ua, ub, uc;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        le;
    logic        ie;
    logic        ide;
    logic [3:0]  ia;
  } stim_t;

  typedef struct packed {
    logic [31:0] dataA, dataB, dataC;
    logic        busyA, busyB, busyC;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] pc_val;
  logic [3:0]  rd_addr_a, rd_addr_b, rd_addr_c;
  logic        rd_use_a, rd_use_b, rd_use_c;
  logic [31:0] rd_data_a, rd_data_b, rd_data_c;
  logic        busy_a, busy_b, busy_c;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        link_en;
  logic        issue_en;
  logic        issue_dest_en;
  logic [3:0]  issue_addr;
  logic        stall;
  logic        pc_redirect;
  logic [31:0] pc_target;

  reg_file_scoreboard dut (
    .clk(clk), .reset(reset), .pc_val(pc_val),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .rd_use_a(rd_use_a), .rd_use_b(rd_use_b), .rd_use_c(rd_use_c),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_data_c(rd_data_c),
    .busy_a(busy_a), .busy_b(busy_b), .busy_c(busy_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .link_en(link_en),
    .issue_en(issue_en), .issue_dest_en(issue_dest_en), .issue_addr(issue_addr),
    .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: plain register and busy arrays plus the pending redirect.
  logic [31:0] modelReg [16];
  logic        modelBusy [16];
  logic        modelRedirect;
  logic [31:0] modelTarget;
  bit          modelValid = 1'b0;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic logic [31:0] expData(input logic [3:0] addr, input stim_t s);
    if (addr == 4'd15) return s.pc + 32'd8;
`ifdef RF_WRITE_BYPASS_EN
    if (s.we && s.wa == addr) return s.wd;
    if (s.le && addr == 4'd14 && !(s.we && s.wa == 4'd14)) return s.pc + 32'd4;
`endif
    return modelReg[addr];
  endfunction

  function automatic logic expBusy(input logic [3:0] addr, input stim_t s);
    if (addr == 4'd15) return 1'b0;
`ifdef RF_WRITE_BYPASS_EN
    if (s.we && s.wa == addr) return 1'b0;
    if (s.le && addr == 4'd14 && !(s.we && s.wa == 4'd14)) return 1'b0;
`endif
    return modelBusy[addr];
  endfunction

  function automatic logic expStall(input stim_t s);
    logic hazard;
    hazard = (s.ua && expBusy(s.ra, s)) || (s.ub && expBusy(s.rb, s)) ||
             (s.uc && expBusy(s.rc, s)) || (s.ide && modelBusy[s.ia]);
    return s.ie && hazard;
  endfunction

  task automatic updateModel(input stim_t s, input logic stalled);
    if (s.reset) begin
      for (int i = 0; i < 16; i++) begin
        modelReg[i]  = 32'd0;
        modelBusy[i] = 1'b0;
      end
      modelRedirect = 1'b0;
      modelTarget   = 32'd0;
      modelValid    = 1'b1;
    end else begin
      if (s.le) begin
        modelReg[14]  = s.pc + 32'd4;
        modelBusy[14] = 1'b0;
      end
      if (s.we && s.wa != 4'd15) modelReg[s.wa] = s.wd;
      if (s.we) modelBusy[s.wa] = 1'b0;
      if (s.ie && s.ide && !stalled && s.ia != 4'd15) modelBusy[s.ia] = 1'b1;
      modelRedirect = s.we && (s.wa == 4'd15);
      if (modelRedirect) modelTarget = {s.wd[31:2], 2'b00};
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    logic stalled;
    reset = s.reset; pc_val = s.pc;
    rd_addr_a = s.ra; rd_addr_b = s.rb; rd_addr_c = s.rc;
    rd_use_a = s.ua; rd_use_b = s.ub; rd_use_c = s.uc;
    wr_en = s.we; wr_addr = s.wa; wr_data = s.wd; link_en = s.le;
    issue_en = s.ie; issue_dest_en = s.ide; issue_addr = s.ia;
    stalled = modelValid ? expStall(s) : 1'b0;
    if (modelValid) begin
      e.dataA = expData(s.ra, s);
      e.dataB = expData(s.rb, s);
      e.dataC = expData(s.rc, s);
      e.busyA = expBusy(s.ra, s);
      e.busyB = expBusy(s.rb, s);
      e.busyC = expBusy(s.rc, s);
      e.stall = stalled;
      e.redirect = modelRedirect;
      e.target = modelTarget;
      expQ.push_back(e);
    end
    @(posedge clk);
    updateModel(s, stalled);
    #1;
  endtask

  task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("rd_data_a", rd_data_a, e.dataA);
    checkField("rd_data_b", rd_data_b, e.dataB);
    checkField("rd_data_c", rd_data_c, e.dataC);
    checkField("busy_a", {31'd0, busy_a}, {31'd0, e.busyA});
    checkField("busy_b", {31'd0, busy_b}, {31'd0, e.busyB});
    checkField("busy_c", {31'd0, busy_c}, {31'd0, e.busyC});
    checkField("stall", {31'd0, stall}, {31'd0, e.stall});
    checkField("pc_redirect", {31'd0, pc_redirect}, {31'd0, e.redirect});
    checkField("pc_target", pc_target, e.target);
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    stim_t s;
    applyStimulus(idleStim());
    s = idleStim(); s.reset = 1'b1;
    applyStimulus(s);

    // Post-reset sweep of every index with pc_val = 0.
    for (int i = 0; i < 16; i++) begin
      s = idleStim(); s.ra = 4'(i); s.rb = 4'(i); s.rc = 4'(i);
      applyStimulus(s);
    end

    // Write R3 while reading it, then read again.
    s = idleStim(); s.we = 1'b1; s.wa = 4'd3; s.wd = 32'hDEADBEEF; s.ra = 4'd3;
    applyStimulus(s);
    s = idleStim(); s.ra = 4'd3;
    applyStimulus(s);

    // PC read, PC write, redirect pulse and its fall.
    s = idleStim(); s.pc = 32'h100; s.rb = 4'd15;
    applyStimulus(s);
    s.we = 1'b1; s.wa = 4'd15; s.wd = 32'h00002003;
    applyStimulus(s);
    s = idleStim(); s.pc = 32'h100; s.rb = 4'd15;
    applyStimulus(s);
    applyStimulus(s);

    // Link alone, then link colliding with a data write to LR.
    s = idleStim(); s.pc = 32'h40; s.le = 1'b1; s.ra = 4'd14;
    applyStimulus(s);
    s = idleStim(); s.ra = 4'd14;
    applyStimulus(s);
    s = idleStim(); s.pc = 32'h40; s.le = 1'b1; s.we = 1'b1; s.wa = 4'd14; s.wd = 32'h55; s.ra = 4'd14;
    applyStimulus(s);
    s = idleStim(); s.ra = 4'd14;
    applyStimulus(s);

    // RAW on R5, clear by write, then set-wins against a same-cycle write.
    s = idleStim(); s.ie = 1'b1; s.ide = 1'b1; s.ia = 4'd5;
    applyStimulus(s);
    s = idleStim(); s.ie = 1'b1; s.ua = 1'b1; s.ra = 4'd5;
    applyStimulus(s);
    applyStimulus(s);
    s = idleStim(); s.we = 1'b1; s.wa = 4'd5; s.wd = 32'h1234_5678; s.ra = 4'd5;
    applyStimulus(s);
    s = idleStim(); s.ra = 4'd5;
    applyStimulus(s);
    s = idleStim(); s.ie = 1'b1; s.ide = 1'b1; s.ia = 4'd5; s.we = 1'b1; s.wa = 4'd5; s.wd = 32'h77;
    applyStimulus(s);
    s = idleStim(); s.ie = 1'b1; s.ua = 1'b1; s.ra = 4'd5;
    applyStimulus(s);

    // Reset overrides a busy register, a PC write and an issue in the same cycle.
    s = idleStim(); s.ie = 1'b1; s.ide = 1'b1; s.ia = 4'd2;
    applyStimulus(s);
    s = idleStim(); s.reset = 1'b1; s.we = 1'b1; s.wa = 4'd15; s.wd = 32'h0000_3000;
    s.ie = 1'b1; s.ide = 1'b1; s.ia = 4'd2; s.ra = 4'd2;
    applyStimulus(s);
    s = idleStim(); s.ra = 4'd2;
    applyStimulus(s);
    applyStimulus(s);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      s = idleStim();
      s.reset = ($urandom_range(0, 63) == 0);
      s.pc = $urandom & 32'hFFFF_FFFC;
      s.ra = 4'($urandom_range(0, 15));
      s.rb = 4'($urandom_range(0, 15));
      s.rc = 4'($urandom_range(0, 15));
      s.ua = 1'($urandom_range(0, 1));
      s.ub = 1'($urandom_range(0, 1));
      s.uc = 1'($urandom_range(0, 1));
      s.we = ($urandom_range(0, 9) < 4);
      s.wa = 4'($urandom_range(0, 15));
      s.wd = $urandom;
      s.le = ($urandom_range(0, 9) == 0);
      s.ie = 1'($urandom_range(0, 1));
      s.ide = ($urandom_range(0, 9) < 7);
      s.ia = 4'($urandom_range(0, 15));
      applyStimulus(s);
    end

    applyStimulus(idleStim());
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
